motor_mixer: RTL
================

MOTOR_MIXER -- requirements
Module: motor_mixer

Interface
REQ-001 SHALL have port clk, input, 1, the only clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset sampled on rising clk.
REQ-003 SHALL have port vld, input, 1, one-cycle strobe that all PD terms and thrst are valid this cycle.
REQ-004 SHALL have port thrst, input, 9, unsigned thrust command.
REQ-005 SHALL have ports ptch_pterm, roll_pterm, yaw_pterm, input, 10 each, signed proportional terms from the PD_math instances.
REQ-006 SHALL have ports ptch_dterm, roll_dterm, yaw_dterm, input, 12 each, signed derivative terms from the PD_math instances.
REQ-007 SHALL have port inertial_cal, input, 1, high while the inertial sensor calibrates.
REQ-008 SHALL have ports frnt_spd, bck_spd, lft_spd, rght_spd, output, 11 each, registered unsigned motor speeds.
REQ-009 SHALL have port spd_vld, output, 1, one-cycle strobe marking new motor speeds.

Function
REQ-010 SHALL be a two-stage pipeline; spd_vld SHALL pulse exactly 2 cycles after the vld that produced it.
REQ-011 SHALL pass back-to-back vld at full rate, with one spd_vld per vld and no drops.
REQ-012 Stage 1, on vld: each axis sum SHALL be the 13-bit signed sum of its sign-extended pterm and dterm, registered; T SHALL be thrst zero-extended plus MIN_RUN_SPEED (512), registered as 11-bit; inertial_cal and thrst==0 SHALL be registered alongside.
REQ-013 Stage 2 SHALL compute in 14-bit signed: frnt = T + ptch - yaw; bck = T - ptch - yaw; lft = T + roll + yaw; rght = T - roll + yaw.
REQ-014 Stage 2 SHALL saturate each result: below 0 gives 0; above 2047 gives 2047; otherwise the low 11 bits.
REQ-015 Mode priority at stage 2 SHALL be: registered inertial_cal high gives all four speeds CAL_SPEED (656); else registered thrst==0 gives all four speeds 0; else the mixed values.
REQ-016 Speed outputs SHALL hold their last value between spd_vld pulses.
REQ-017 An inertial_cal change between stage 1 and stage 2 SHALL NOT affect an in-flight sample; the value captured at stage 1 governs.
REQ-018 Stage-1 and stage-2 data registers SHALL update only when their own valid bit is set.

Reset
REQ-019 rst_n low SHALL clear both pipeline valid bits, spd_vld, and all four speed outputs to 0 on the next rising clk.
REQ-020 A reset asserted while a sample is in flight SHALL discard that sample, so no spd_vld pulse results from it.
REQ-021 A vld sampled in the same cycle that rst_n is low SHALL be ignored.

Structure
REQ-022 A shared package SHALL hold MIN_RUN_SPEED = 11'd512, CAL_SPEED = 11'd656, and the width constants for pterm, dterm, axis sum and speed.
REQ-023 The 14-bit-signed to 11-bit-unsigned saturator SHALL be one sub-module, spd_sat, instanced four times.
REQ-024 No other sub-modules SHALL be used.

Verification
REQ-025 Reset, then hold rst_n low 2 cycles -> all speeds 0 and spd_vld 0.
REQ-026 thrst=100 with all terms 0, vld pulsed in cycle N -> spd_vld high only in cycle N+2, all four speeds 612.
REQ-027 thrst=100, ptch_pterm=100, ptch_dterm=50, other terms 0 -> frnt=762, bck=462, lft=612, rght=612.
REQ-028 thrst=511, ptch_pterm=511, ptch_dterm=2047, yaw terms=0 -> frnt=2047 (saturated high), bck=0 (saturated low).
REQ-029 inertial_cal=1 with arbitrary terms -> all four speeds 656; inertial_cal=0, thrst=0, ptch_pterm=200 -> all four speeds 0.
REQ-030 vld in cycle N, rst_n low in cycle N+1 -> no spd_vld pulse, speeds 0; three back-to-back vld pulses -> three consecutive spd_vld pulses.

Source files
------------

// File: rtl/motor_mixer_pkg.sv
// Shared widths, speed constants and small helpers for the quadcopter motor mixer.
package motor_mixer_pkg;

    localparam int THRST_W = 9;
    localparam int PTERM_W = 10;
    localparam int DTERM_W = 12;
    localparam int SUM_W   = 13;
    localparam int MIX_W   = 14;
    localparam int SPD_W   = 11;

    localparam logic [SPD_W-1:0] MIN_RUN_SPEED = 11'd512;
    localparam logic [SPD_W-1:0] CAL_SPEED     = 11'd656;
    localparam logic [SPD_W-1:0] SPD_MAX       = 11'd2047;

    typedef enum logic [1:0] {
        MODE_MIX,
        MODE_CAL,
        MODE_OFF
    } mode_e;

    // Calibration outranks a zero-thrust shutdown.
    function automatic mode_e selectMode(input logic cal, input logic thrZero);
        if (cal)
            return MODE_CAL;
        else if (thrZero)
            return MODE_OFF;
        else
            return MODE_MIX;
    endfunction

    // Two's-complement sum of sign-extended P and D terms; 13 bits cannot overflow.
    function automatic logic [SUM_W-1:0] axisSum(input logic [PTERM_W-1:0] p,
                                                 input logic [DTERM_W-1:0] d);
        logic [SUM_W-1:0] pExt;
        logic [SUM_W-1:0] dExt;
        pExt = {{(SUM_W-PTERM_W){p[PTERM_W-1]}}, p};
        dExt = {{(SUM_W-DTERM_W){d[DTERM_W-1]}}, d};
        return pExt + dExt;
    endfunction

endpackage

// File: rtl/motor_mixer_spd_sat.sv
// Clamps a 14-bit two's-complement mix result into the 0..2047 motor speed range.
module spd_sat
    import motor_mixer_pkg::*;
(
    input  logic [MIX_W-1:0] mix_i,
    output logic [SPD_W-1:0] spd_o
);

    // Sign bit means negative; any set bit between the sign and bit 10 means too large.
    always_comb begin
        spd_o = mix_i[SPD_W-1:0];
        if (mix_i[MIX_W-1])
            spd_o = '0;
        else if (|mix_i[MIX_W-2:SPD_W])
            spd_o = SPD_MAX;
    end

endmodule

// File: rtl/motor_mixer.sv
// Two-stage mixer: stage 1 sums PD terms and offsets thrust, stage 2 mixes, saturates and selects mode.
module motor_mixer
    import motor_mixer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic [THRST_W-1:0] thrst,
    input  logic [PTERM_W-1:0] ptch_pterm,
    input  logic [PTERM_W-1:0] roll_pterm,
    input  logic [PTERM_W-1:0] yaw_pterm,
    input  logic [DTERM_W-1:0] ptch_dterm,
    input  logic [DTERM_W-1:0] roll_dterm,
    input  logic [DTERM_W-1:0] yaw_dterm,
    input  logic               inertial_cal,
    output logic [SPD_W-1:0]   frnt_spd,
    output logic [SPD_W-1:0]   bck_spd,
    output logic [SPD_W-1:0]   lft_spd,
    output logic [SPD_W-1:0]   rght_spd,
    output logic               spd_vld
);

    logic               s1Vld_q,   s1Vld_d;
    logic [SUM_W-1:0]   ptchSum_q, ptchSum_d;
    logic [SUM_W-1:0]   rollSum_q, rollSum_d;
    logic [SUM_W-1:0]   yawSum_q,  yawSum_d;
    logic [SPD_W-1:0]   thrT_q,    thrT_d;
    logic               cal_q,     cal_d;
    logic               thrZero_q, thrZero_d;

    logic               s2Vld_q,   s2Vld_d;
    logic [SPD_W-1:0]   frntSpd_q, frntSpd_d;
    logic [SPD_W-1:0]   bckSpd_q,  bckSpd_d;
    logic [SPD_W-1:0]   lftSpd_q,  lftSpd_d;
    logic [SPD_W-1:0]   rghtSpd_q, rghtSpd_d;

    logic [MIX_W-1:0]   tExt, ptchExt, rollExt, yawExt;
    logic [MIX_W-1:0]   frntMix, bckMix, lftMix, rghtMix;
    logic [SPD_W-1:0]   frntSat, bckSat, lftSat, rghtSat;
    mode_e              mode;

    // Stage 1 captures everything on vld, including the mode inputs, so later changes cannot leak in.
    always_comb begin
        s1Vld_d   = vld;
        ptchSum_d = ptchSum_q;
        rollSum_d = rollSum_q;
        yawSum_d  = yawSum_q;
        thrT_d    = thrT_q;
        cal_d     = cal_q;
        thrZero_d = thrZero_q;
        if (vld) begin
            ptchSum_d = axisSum(ptch_pterm, ptch_dterm);
            rollSum_d = axisSum(roll_pterm, roll_dterm);
            yawSum_d  = axisSum(yaw_pterm, yaw_dterm);
            thrT_d    = {{(SPD_W-THRST_W){1'b0}}, thrst} + MIN_RUN_SPEED;
            cal_d     = inertial_cal;
            thrZero_d = (thrst == '0);
        end
    end

    always_comb begin
        tExt    = {{(MIX_W-SPD_W){1'b0}}, thrT_q};
        ptchExt = {{(MIX_W-SUM_W){ptchSum_q[SUM_W-1]}}, ptchSum_q};
        rollExt = {{(MIX_W-SUM_W){rollSum_q[SUM_W-1]}}, rollSum_q};
        yawExt  = {{(MIX_W-SUM_W){yawSum_q[SUM_W-1]}}, yawSum_q};
        frntMix = tExt + ptchExt - yawExt;
        bckMix  = tExt - ptchExt - yawExt;
        lftMix  = tExt + rollExt + yawExt;
        rghtMix = tExt - rollExt + yawExt;
    end

    spd_sat u_frntSat (.mix_i(frntMix), .spd_o(frntSat));
    spd_sat u_bckSat  (.mix_i(bckMix),  .spd_o(bckSat));
    spd_sat u_lftSat  (.mix_i(lftMix),  .spd_o(lftSat));
    spd_sat u_rghtSat (.mix_i(rghtMix), .spd_o(rghtSat));

    // Speeds only move when a stage-1 sample arrives; otherwise they hold their last value.
    always_comb begin
        mode      = selectMode(cal_q, thrZero_q);
        s2Vld_d   = s1Vld_q;
        frntSpd_d = frntSpd_q;
        bckSpd_d  = bckSpd_q;
        lftSpd_d  = lftSpd_q;
        rghtSpd_d = rghtSpd_q;
        if (s1Vld_q) begin
            case (mode)
                MODE_CAL: begin
                    frntSpd_d = CAL_SPEED;
                    bckSpd_d  = CAL_SPEED;
                    lftSpd_d  = CAL_SPEED;
                    rghtSpd_d = CAL_SPEED;
                end
                MODE_OFF: begin
                    frntSpd_d = '0;
                    bckSpd_d  = '0;
                    lftSpd_d  = '0;
                    rghtSpd_d = '0;
                end
                default: begin
                    frntSpd_d = frntSat;
                    bckSpd_d  = bckSat;
                    lftSpd_d  = lftSat;
                    rghtSpd_d = rghtSat;
                end
            endcase
        end
    end

    // Reset wins over vld in the same cycle and flushes anything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Vld_q   <= 1'b0;
            ptchSum_q <= '0;
            rollSum_q <= '0;
            yawSum_q  <= '0;
            thrT_q    <= '0;
            cal_q     <= 1'b0;
            thrZero_q <= 1'b0;
            s2Vld_q   <= 1'b0;
            frntSpd_q <= '0;
            bckSpd_q  <= '0;
            lftSpd_q  <= '0;
            rghtSpd_q <= '0;
        end else begin
            s1Vld_q   <= s1Vld_d;
            ptchSum_q <= ptchSum_d;
            rollSum_q <= rollSum_d;
            yawSum_q  <= yawSum_d;
            thrT_q    <= thrT_d;
            cal_q     <= cal_d;
            thrZero_q <= thrZero_d;
            s2Vld_q   <= s2Vld_d;
            frntSpd_q <= frntSpd_d;
            bckSpd_q  <= bckSpd_d;
            lftSpd_q  <= lftSpd_d;
            rghtSpd_q <= rghtSpd_d;
        end
    end

    assign spd_vld  = s2Vld_q;
    assign frnt_spd = frntSpd_q;
    assign bck_spd  = bckSpd_q;
    assign lft_spd  = lftSpd_q;
    assign rght_spd = rghtSpd_q;

endmodule
